d24: RTL and testbench



---
 rtl/d24.sv | 80 ++++++++
 tb/tb_d24.sv | 135 +++++++++++++
 2 files changed

// File: rtl/d24.sv
// Registered select-to-one-hot decoder with one-cycle latency, synchronous active-low reset.
// Optional per-line saturating hit counters are enabled by defining D24_HIT_CNT_EN.
module d24 #(
    parameter int unsigned IN_W        = 2,
    parameter bit          OUT_ACT_LOW = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IN_W-1:0]          a,
    input  logic                     e,
`ifdef D24_HIT_CNT_EN
    input  logic [IN_W-1:0]          cnt_sel,
    output logic [7:0]               cnt_out,
`endif
    output logic [(1<<IN_W)-1:0]     y,
    output logic                     valid
);

    localparam int unsigned OUT_W = 1 << IN_W;
    localparam logic [OUT_W-1:0] IDLE = {OUT_W{OUT_ACT_LOW}};

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] y_d, y_q;
    logic             valid_d, valid_q;

    // NOTE: combinational next-state uses blocking '=' with a default first
    // (no latches); the flops below use non-blocking '<=' only.
    always_comb begin
        onehot = '0;
        if (e) begin
            onehot[a] = 1'b1;
        end
        y_d     = onehot ^ IDLE;
        valid_d = e;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= IDLE;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;

`ifdef D24_HIT_CNT_EN
    logic [7:0] cnt_d [OUT_W];
    logic [7:0] cnt_q [OUT_W];
    logic [7:0] cnt_out_d, cnt_out_q;

    always_comb begin
        cnt_d = cnt_q;
        if (e && (cnt_q[a] != 8'hFF)) begin
            cnt_d[a] = cnt_q[a] + 8'd1;
        end
        cnt_out_d = cnt_q[cnt_sel];
    end

    // NOTE: this small counter array is cleared on reset, so it maps to flops
    // rather than a RAM macro; a large memory would normally be left unreset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_W; i++) begin
                cnt_q[i] <= '0;
            end
            cnt_out_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cnt_out_q <= cnt_out_d;
        end
    end

    assign cnt_out = cnt_out_q;
`endif

endmodule

// File: tb/tb_d24.sv
// Scoreboard bench for d24: a driver pushes model predictions, a monitor pops and compares.
// Counter checks are included when D24_HIT_CNT_EN is defined.
module tb_d24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] a;
    logic       e;
    logic [1:0] sel;
    logic [3:0] y, y_n;
    logic       valid, valid_n;
`ifdef D24_HIT_CNT_EN
    logic [7:0] cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] y;
        logic [3:0] y_n;
        logic       valid;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   hits[4];

    always #5 clk = ~clk;

    d24 #(.IN_W(2), .OUT_ACT_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .e(e),
`ifdef D24_HIT_CNT_EN
        .cnt_sel(sel), .cnt_out(cnt_out),
`endif
        .y(y), .valid(valid)
    );

    d24 #(.IN_W(2), .OUT_ACT_LOW(1'b1)) dut_n (
        .clk(clk), .rst_n(rst_n), .a(a), .e(e),
`ifdef D24_HIT_CNT_EN
        .cnt_sel(sel), .cnt_out(),
`endif
        .y(y_n), .valid(valid_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Apply one cycle of stimulus and predict what the outputs show after the next edge.
    task automatic drive(input logic r, input logic [1:0] av, input logic ev, input logic [1:0] sv);
        exp_t x;
        @(negedge clk);
        rst_n = r; a = av; e = ev; sel = sv;
        if (!r) begin
            x.y = 4'd0; x.valid = 1'b0; x.cnt = 8'd0;
            for (int i = 0; i < 4; i++) hits[i] = 0;
        end else begin
            x.y     = ev ? 4'(1 << av) : 4'd0;
            x.valid = ev;
            x.cnt   = 8'(hits[sv]);
            if (ev && hits[av] < 255) hits[av] = hits[av] + 1;
        end
        x.y_n = ~x.y;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("y",       32'(y),       32'(x.y));
                check("valid",   32'(valid),   32'(x.valid));
                check("y_n",     32'(y_n),     32'(x.y_n));
                check("valid_n", 32'(valid_n), 32'(x.valid));
`ifdef D24_HIT_CNT_EN
                check("cnt_out", 32'(cnt_out), 32'(x.cnt));
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; a = 2'b11; e = 1'b1; sel = 2'b00;
        for (int i = 0; i < 4; i++) hits[i] = 0;

        // Reset held two cycles with a live select, then release.
        drive(1'b0, 2'b11, 1'b1, 2'b00);
        drive(1'b0, 2'b11, 1'b1, 2'b00);
        drive(1'b1, 2'b11, 1'b1, 2'b00);

        // Full sweep, disable sweep, re-enable.
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 1'b1, 2'(i));
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 1'b0, 2'(i));
        drive(1'b1, 2'b10, 1'b1, 2'b10);

        // Mid-stream reset during a sweep.
        drive(1'b1, 2'b00, 1'b1, 2'b00);
        drive(1'b0, 2'b01, 1'b1, 2'b01);
        drive(1'b1, 2'b10, 1'b1, 2'b10);
        drive(1'b1, 2'b11, 1'b1, 2'b11);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(15) != 0), 2'($urandom), 1'($urandom), 2'($urandom));
        end

        // Saturation: clear, hammer line 2 for 300 cycles, read lines 2 and 0.
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        for (int i = 0; i < 300; i++) drive(1'b1, 2'b10, 1'b1, 2'b10);
        drive(1'b1, 2'b00, 1'b0, 2'b10);
        drive(1'b1, 2'b00, 1'b0, 2'b00);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
